punc_control: RTL and testbench

- Control FSM for the PUnC LC3 processor. It sits directly upstream of the PUnC datapath and drives every datapath select, load and write-enable.
- It consumes the instruction register contents and the n/z/p condition flags that the datapath produces.
- Implements fetch/decode/execute sequencing for the LC3 subset ADD, AND, NOT, BR, JMP/RET, JSR/JSRR, LD, LDI, LDR, LEA, ST, STI, STR and HALT.

---
 rtl/punc_control_if.sv | 49 ++++
 rtl/punc_control.sv | 213 +++++++++++++++++++++
 tb/tb_punc_control.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/punc_control_if.sv
// Control/status bundle between the PUnC control FSM and the PUnC datapath.
// master = controller (drives every select/enable, reads IR and flags).
// slave  = datapath (drives IR and n/z/p, consumes the controls).
interface punc_control_if;
  logic [15:0] ir;
  logic        n;
  logic        z;
  logic        p;

  logic        pc_ld;
  logic        pc_clr;
  logic        pc_inc;
  logic        ir_ld;
  logic        pc_data_sel;
  logic        pc_add_sel;
  logic [1:0]  addr_mem_sel;
  logic        w_en_mem;
  logic [1:0]  w_rf_sel;
  logic [2:0]  r_addr_0_rf;
  logic [2:0]  r_addr_1_rf;
  logic [2:0]  w_addr_rf;
  logic        w_en_rf;
  logic [15:0] sext_data;
  logic        a_sel;
  logic        b_sel;
  logic [1:0]  alu_sel;
  logic        nzp_sel;
  logic        n_ld;
  logic        z_ld;
  logic        p_ld;
  logic        store_ld;
  logic        halted;

  modport master (
    input  ir, n, z, p,
    output pc_ld, pc_clr, pc_inc, ir_ld, pc_data_sel, pc_add_sel,
           addr_mem_sel, w_en_mem, w_rf_sel, r_addr_0_rf, r_addr_1_rf,
           w_addr_rf, w_en_rf, sext_data, a_sel, b_sel, alu_sel, nzp_sel,
           n_ld, z_ld, p_ld, store_ld, halted
  );

  modport slave (
    output ir, n, z, p,
    input  pc_ld, pc_clr, pc_inc, ir_ld, pc_data_sel, pc_add_sel,
           addr_mem_sel, w_en_mem, w_rf_sel, r_addr_0_rf, r_addr_1_rf,
           w_addr_rf, w_en_rf, sext_data, a_sel, b_sel, alu_sel, nzp_sel,
           n_ld, z_ld, p_ld, store_ld, halted
  );
endinterface

// File: rtl/punc_control.sv
// PUnC LC3 control FSM: INIT/FETCH/DECODE/EXEC(/EXEC2)/HALT sequencing of the datapath.
// Latency: 3 cycles per instruction, 4 for LDI/STI; controls are combinational from state and IR.
// No backpressure: the datapath always completes a step in one cycle. Optional: PUNC_INSTR_COUNT_EN.
module punc_control #(
  parameter logic [3:0] HALT_OPCODE = 4'hF,
  parameter int         STATE_W     = 3
) (
  input  logic           clk,
  input  logic           rst,
  punc_control_if.master ctl
`ifdef PUNC_INSTR_COUNT_EN
  ,
  output logic [15:0]    instr_count
`endif
);

  typedef enum logic [STATE_W-1:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  state_t      state;
  logic [3:0]  opcode;
  logic        indirect;
  logic        br_taken;
  logic [15:0] sext5;
  logic [15:0] sext6;
  logic [15:0] sext9;

  assign opcode   = ctl.ir[15:12];
  assign indirect = (opcode == OP_LDI) || (opcode == OP_STI);
  assign br_taken = (ctl.ir[11] & ctl.n) | (ctl.ir[10] & ctl.z) | (ctl.ir[9] & ctl.p);
  assign sext5    = {{11{ctl.ir[4]}}, ctl.ir[4:0]};
  assign sext6    = {{10{ctl.ir[5]}}, ctl.ir[5:0]};
  assign sext9    = {{7{ctl.ir[8]}}, ctl.ir[8:0]};

  // State sequencing; reset returns to INIT from anywhere, HALT holds until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_INIT;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
        S_EXEC:   state <= indirect ? S_EXEC2 : S_FETCH;
        S_EXEC2:  state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_INIT;
      endcase
    end
  end

`ifdef PUNC_INSTR_COUNT_EN
  logic retire;
  assign retire = ((state == S_EXEC) && !indirect) || (state == S_EXEC2);

  // Count instructions retiring into FETCH; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_count <= 16'd0;
    end else if (retire) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

  // Datapath controls decoded from state and IR; everything forced low while in reset.
  always_comb begin
    ctl.pc_ld        = 1'b0;
    ctl.pc_clr       = 1'b0;
    ctl.pc_inc       = 1'b0;
    ctl.ir_ld        = 1'b0;
    ctl.pc_data_sel  = 1'b0;
    ctl.pc_add_sel   = 1'b0;
    ctl.addr_mem_sel = 2'b00;
    ctl.w_en_mem     = 1'b0;
    ctl.w_rf_sel     = 2'b00;
    ctl.r_addr_0_rf  = 3'd0;
    ctl.r_addr_1_rf  = 3'd0;
    ctl.w_addr_rf    = 3'd0;
    ctl.w_en_rf      = 1'b0;
    ctl.sext_data    = 16'd0;
    ctl.a_sel        = 1'b0;
    ctl.b_sel        = 1'b0;
    ctl.alu_sel      = 2'b00;
    ctl.nzp_sel      = 1'b0;
    ctl.n_ld         = 1'b0;
    ctl.z_ld         = 1'b0;
    ctl.p_ld         = 1'b0;
    ctl.store_ld     = 1'b0;
    ctl.halted       = 1'b0;
    if (rst) begin
      case (state)
        S_INIT: ctl.pc_clr = 1'b1;
        S_FETCH: begin
          ctl.ir_ld  = 1'b1;
          ctl.pc_inc = 1'b1;
        end
        S_EXEC: begin
          case (opcode)
            OP_ADD, OP_AND, OP_NOT: begin
              ctl.r_addr_0_rf = ctl.ir[8:6];
              ctl.a_sel       = 1'b1;
              if (opcode == OP_NOT) begin
                ctl.alu_sel = 2'b11;
              end else begin
                ctl.alu_sel = (opcode == OP_AND) ? 2'b01 : 2'b00;
                if (ctl.ir[5]) begin
                  ctl.b_sel     = 1'b1;
                  ctl.sext_data = sext5;
                end else begin
                  ctl.r_addr_1_rf = ctl.ir[2:0];
                end
              end
              ctl.w_rf_sel  = 2'b10;
              ctl.w_addr_rf = ctl.ir[11:9];
              ctl.w_en_rf   = 1'b1;
              ctl.n_ld      = 1'b1;
              ctl.z_ld      = 1'b1;
              ctl.p_ld      = 1'b1;
            end
            OP_BR: begin
              if (br_taken) begin
                ctl.pc_ld      = 1'b1;
                ctl.pc_add_sel = 1'b1;
              end
            end
            OP_JMP, OP_JSR: begin
              ctl.pc_ld = 1'b1;
              if (opcode == OP_JSR) begin
                ctl.w_addr_rf = 3'd7;
                ctl.w_en_rf   = 1'b1;
              end
              // JSR with ir[11] uses the PC+off11 adder (both selects 0); the rest jump via a register.
              if (opcode == OP_JMP || !ctl.ir[11]) begin
                ctl.r_addr_0_rf = ctl.ir[8:6];
                ctl.a_sel       = 1'b1;
                ctl.alu_sel     = 2'b10;
                ctl.pc_data_sel = 1'b1;
              end
            end
            OP_LD, OP_LDR, OP_ST, OP_STR, OP_LEA, OP_LDI, OP_STI: begin
              // Effective address (or LEA result) = base + offset through the ALU.
              ctl.b_sel = 1'b1;
              if (opcode == OP_LDR || opcode == OP_STR) begin
                ctl.a_sel       = 1'b1;
                ctl.r_addr_0_rf = ctl.ir[8:6];
                ctl.sext_data   = sext6;
              end else begin
                ctl.sext_data = sext9;
              end
              if (opcode != OP_LEA) ctl.addr_mem_sel = 2'b01;
              if (opcode == OP_LEA) begin
                ctl.w_rf_sel  = 2'b10;
                ctl.w_addr_rf = ctl.ir[11:9];
                ctl.w_en_rf   = 1'b1;
              end
              if (opcode == OP_LD || opcode == OP_LDR) begin
                ctl.w_rf_sel  = 2'b01;
                ctl.w_addr_rf = ctl.ir[11:9];
                ctl.w_en_rf   = 1'b1;
                ctl.nzp_sel   = 1'b1;
                ctl.n_ld      = 1'b1;
                ctl.z_ld      = 1'b1;
                ctl.p_ld      = 1'b1;
              end
              if (opcode == OP_ST || opcode == OP_STR) begin
                ctl.r_addr_1_rf = ctl.ir[11:9];
                ctl.w_en_mem    = 1'b1;
              end
              if (indirect) ctl.store_ld = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC2: begin
          // Second access goes through the pointer captured in the store register.
          ctl.addr_mem_sel = 2'b10;
          if (opcode == OP_LDI) begin
            ctl.w_rf_sel  = 2'b01;
            ctl.w_en_rf   = 1'b1;
            ctl.w_addr_rf = ctl.ir[11:9];
            ctl.nzp_sel   = 1'b1;
            ctl.n_ld      = 1'b1;
            ctl.z_ld      = 1'b1;
            ctl.p_ld      = 1'b1;
          end
          if (opcode == OP_STI) begin
            ctl.r_addr_1_rf = ctl.ir[11:9];
            ctl.w_en_mem    = 1'b1;
          end
        end
        S_HALT: ctl.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: fixed EXEC vectors, hand sequences for LDI/STI/HALT/reset,
// then random instructions checked against a reference model of the control rules.
module tb_punc_control;

  typedef struct packed {
    logic        pc_ld, pc_clr, pc_inc, ir_ld, pc_data_sel, pc_add_sel;
    logic [1:0]  addr_mem_sel;
    logic        w_en_mem;
    logic [1:0]  w_rf_sel;
    logic [2:0]  r0, r1, wa;
    logic        w_en_rf;
    logic [15:0] sext;
    logic        a_sel, b_sel;
    logic [1:0]  alu;
    logic        nzp_sel, n_ld, z_ld, p_ld, store_ld, halted;
  } ctl_t;

  typedef enum int {PH_INIT, PH_FETCH, PH_DECODE, PH_EXEC, PH_EXEC2, PH_HALT} phase_t;

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  nzp;
    ctl_t        exp;
  } tv_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  punc_control_if bus();
`ifdef PUNC_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  punc_control #(.HALT_OPCODE(4'hF), .STATE_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .ctl(bus)
`ifdef PUNC_INSTR_COUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic ctl_t observe();
    ctl_t c;
    c.pc_ld = bus.pc_ld;           c.pc_clr = bus.pc_clr;
    c.pc_inc = bus.pc_inc;         c.ir_ld = bus.ir_ld;
    c.pc_data_sel = bus.pc_data_sel; c.pc_add_sel = bus.pc_add_sel;
    c.addr_mem_sel = bus.addr_mem_sel; c.w_en_mem = bus.w_en_mem;
    c.w_rf_sel = bus.w_rf_sel;     c.r0 = bus.r_addr_0_rf;
    c.r1 = bus.r_addr_1_rf;        c.wa = bus.w_addr_rf;
    c.w_en_rf = bus.w_en_rf;       c.sext = bus.sext_data;
    c.a_sel = bus.a_sel;           c.b_sel = bus.b_sel;
    c.alu = bus.alu_sel;           c.nzp_sel = bus.nzp_sel;
    c.n_ld = bus.n_ld;             c.z_ld = bus.z_ld;
    c.p_ld = bus.p_ld;             c.store_ld = bus.store_ld;
    c.halted = bus.halted;
    return c;
  endfunction

  task automatic check_ctl(input string name, input ctl_t exp);
    ctl_t act;
    act = observe();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (ir=%h)", name, act, exp, bus.ir);
    end
  endtask

`ifdef PUNC_INSTR_COUNT_EN
  task automatic check_cnt(input string name, input logic [15:0] exp);
    checks++;
    if (instr_count !== exp) begin
      errors++;
      $display("FAIL %s: instr_count got %h, expected %h", name, instr_count, exp);
    end
  endtask
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] i, input logic [2:0] f);
    bus.ir = i;
    {bus.n, bus.z, bus.p} = f;
  endtask

  // Steps one instruction from FETCH back to FETCH without checking.
  task automatic run_instr(input logic [15:0] i);
    drive(i, 3'b000);
    tick();
    tick();
    if (i[15:12] == 4'hA || i[15:12] == 4'hB) tick();
    tick();
  endtask

  function automatic ctl_t k_init();
    ctl_t c = '0;
    c.pc_clr = 1'b1;
    return c;
  endfunction

  function automatic ctl_t k_fetch();
    ctl_t c = '0;
    c.ir_ld = 1'b1;
    c.pc_inc = 1'b1;
    return c;
  endfunction

  function automatic ctl_t k_halt();
    ctl_t c = '0;
    c.halted = 1'b1;
    return c;
  endfunction

  // Reference model: instruction classes and where each result/address comes from.
  function automatic ctl_t model_ctl(input phase_t ph, input logic [15:0] i,
                                     input logic [2:0] f, input logic r);
    ctl_t c = '0;
    int   op = int'(i[15:12]);
    bit   is_alu   = (op == 1) || (op == 5) || (op == 9);
    bit   is_load  = (op == 2) || (op == 6);
    bit   is_store = (op == 3) || (op == 7);
    bit   is_ind   = (op == 10) || (op == 11);
    bit   base_reg = (op == 6) || (op == 7);
    bit   reg_jump;
    logic [15:0] off = base_reg ? {{10{i[5]}}, i[5:0]} : {{7{i[8]}}, i[8:0]};
    if (!r) return c;
    case (ph)
      PH_INIT:  c = k_init();
      PH_FETCH: c = k_fetch();
      PH_HALT:  c = k_halt();
      PH_EXEC: begin
        if (is_load || is_store || is_ind || op == 14) begin
          c.a_sel = base_reg;
          c.r0 = base_reg ? i[8:6] : 3'd0;
          c.b_sel = 1'b1;
          c.sext = off;
          if (op != 14) c.addr_mem_sel = 2'd1;
        end
        if (is_ind) c.store_ld = 1'b1;
        if (is_store) begin c.r1 = i[11:9]; c.w_en_mem = 1'b1; end
        if (is_load) begin
          c.w_rf_sel = 2'd1; c.wa = i[11:9]; c.w_en_rf = 1'b1;
          c.nzp_sel = 1'b1; {c.n_ld, c.z_ld, c.p_ld} = 3'b111;
        end
        if (op == 14) begin c.w_rf_sel = 2'd2; c.wa = i[11:9]; c.w_en_rf = 1'b1; end
        if (is_alu) begin
          c.r0 = i[8:6]; c.a_sel = 1'b1;
          c.alu = (op == 1) ? 2'd0 : (op == 5) ? 2'd1 : 2'd3;
          if (op != 9) begin
            if (i[5]) begin c.b_sel = 1'b1; c.sext = {{11{i[4]}}, i[4:0]}; end
            else c.r1 = i[2:0];
          end
          c.w_rf_sel = 2'd2; c.wa = i[11:9]; c.w_en_rf = 1'b1;
          {c.n_ld, c.z_ld, c.p_ld} = 3'b111;
        end
        if (op == 0 && (i[11:9] & f) != 3'b000) begin c.pc_ld = 1'b1; c.pc_add_sel = 1'b1; end
        if (op == 4) begin c.wa = 3'd7; c.w_en_rf = 1'b1; c.pc_ld = 1'b1; end
        reg_jump = (op == 12) || (op == 4 && !i[11]);
        if (reg_jump) begin
          c.r0 = i[8:6]; c.a_sel = 1'b1; c.alu = 2'd2; c.pc_data_sel = 1'b1; c.pc_ld = 1'b1;
        end
      end
      PH_EXEC2: begin
        c.addr_mem_sel = 2'd2;
        if (op == 10) begin
          c.w_rf_sel = 2'd1; c.w_en_rf = 1'b1; c.wa = i[11:9];
          c.nzp_sel = 1'b1; {c.n_ld, c.z_ld, c.p_ld} = 3'b111;
        end
        if (op == 11) begin c.r1 = i[11:9]; c.w_en_mem = 1'b1; end
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic phase_t next_phase(input phase_t ph, input logic [15:0] i);
    case (ph)
      PH_INIT:   return PH_FETCH;
      PH_FETCH:  return PH_DECODE;
      PH_DECODE: return (i[15:12] == 4'hF) ? PH_HALT : PH_EXEC;
      PH_EXEC:   return (i[15:12] == 4'hA || i[15:12] == 4'hB) ? PH_EXEC2 : PH_FETCH;
      PH_EXEC2:  return PH_FETCH;
      default:   return PH_HALT;
    endcase
  endfunction

  initial begin
    ctl_t        e;
    tv_t         tv[$];
    phase_t      ph;
    phase_t      nph;
    logic [15:0] cur_ir;
    logic [2:0]  fl;
    logic        r;
    int          cnt;

    rst = 1'b0;
    drive(16'h0000, 3'b000);
    tick();
    tick();
    @(negedge clk);
    check_ctl("reset_outputs_zero", '0);
`ifdef PUNC_INSTR_COUNT_EN
    check_cnt("reset_count", 16'd0);
`endif
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_ctl("init_pc_clr", k_init());
    tick();

    // EXEC-cycle vectors, expectations written out by hand.
    e = '0; e.r0 = 3'd1; e.a_sel = 1; e.b_sel = 1; e.sext = 16'h0001; e.w_rf_sel = 2; e.wa = 3'd1;
    e.w_en_rf = 1; {e.n_ld, e.z_ld, e.p_ld} = 3'b111; tv.push_back('{16'h1261, 3'b000, e});
    e = '0; e.r0 = 3'd2; e.r1 = 3'd3; e.a_sel = 1; e.alu = 2'd1; e.w_rf_sel = 2; e.wa = 3'd1;
    e.w_en_rf = 1; {e.n_ld, e.z_ld, e.p_ld} = 3'b111; tv.push_back('{16'h5283, 3'b000, e});
    e = '0; e.a_sel = 1; e.b_sel = 1; e.sext = 16'hFFFF; e.w_rf_sel = 2;
    e.w_en_rf = 1; {e.n_ld, e.z_ld, e.p_ld} = 3'b111; tv.push_back('{16'h103F, 3'b000, e});
    e = '0; e.r0 = 3'd2; e.a_sel = 1; e.alu = 2'd3; e.w_rf_sel = 2; e.wa = 3'd3;
    e.w_en_rf = 1; {e.n_ld, e.z_ld, e.p_ld} = 3'b111; tv.push_back('{16'h96BF, 3'b000, e});
    e = '0; e.pc_ld = 1; e.pc_add_sel = 1; tv.push_back('{16'h0402, 3'b010, e});
    e = '0; tv.push_back('{16'h0402, 3'b100, e});
    e = '0; tv.push_back('{16'h0002, 3'b111, e});
    e = '0; e.pc_ld = 1; e.pc_add_sel = 1; tv.push_back('{16'h0E02, 3'b001, e});
    e = '0; e.r0 = 3'd5; e.a_sel = 1; e.alu = 2'd2; e.pc_data_sel = 1; e.pc_ld = 1;
    tv.push_back('{16'hC140, 3'b000, e});
    e = '0; e.wa = 3'd7; e.w_en_rf = 1; e.pc_ld = 1; tv.push_back('{16'h4802, 3'b000, e});
    e = '0; e.wa = 3'd7; e.w_en_rf = 1; e.pc_ld = 1; e.r0 = 3'd7; e.a_sel = 1; e.alu = 2'd2;
    e.pc_data_sel = 1; tv.push_back('{16'h41C0, 3'b000, e});
    e = '0; e.b_sel = 1; e.sext = 16'hFFFD; e.addr_mem_sel = 1; e.w_rf_sel = 1; e.wa = 3'd2;
    e.w_en_rf = 1; e.nzp_sel = 1; {e.n_ld, e.z_ld, e.p_ld} = 3'b111; tv.push_back('{16'h25FD, 3'b000, e});
    e = '0; e.r0 = 3'd6; e.a_sel = 1; e.b_sel = 1; e.sext = 16'hFFE0; e.addr_mem_sel = 1;
    e.w_rf_sel = 1; e.wa = 3'd4; e.w_en_rf = 1; e.nzp_sel = 1; {e.n_ld, e.z_ld, e.p_ld} = 3'b111;
    tv.push_back('{16'h69A0, 3'b000, e});
    e = '0; e.b_sel = 1; e.sext = 16'h00FF; e.w_rf_sel = 2; e.wa = 3'd5; e.w_en_rf = 1;
    tv.push_back('{16'hEAFF, 3'b111, e});
    e = '0; e.b_sel = 1; e.sext = 16'h0001; e.addr_mem_sel = 1; e.r1 = 3'd3; e.w_en_mem = 1;
    tv.push_back('{16'h3601, 3'b000, e});
    e = '0; e.r0 = 3'd2; e.a_sel = 1; e.b_sel = 1; e.sext = 16'h0005; e.addr_mem_sel = 1;
    e.r1 = 3'd1; e.w_en_mem = 1; tv.push_back('{16'h7285, 3'b000, e});
    e = '0; tv.push_back('{16'h8000, 3'b111, e});
    e = '0; tv.push_back('{16'hD123, 3'b111, e});

    foreach (tv[k]) begin
      drive(tv[k].ir, tv[k].nzp);
      @(negedge clk);
      check_ctl($sformatf("fetch[%0d]", k), k_fetch());
      tick();
      @(negedge clk);
      check_ctl($sformatf("decode[%0d]", k), '0);
      tick();
      @(negedge clk);
      check_ctl($sformatf("exec[%0d]", k), tv[k].exp);
      tick();
    end

    // LDI: four cycles, second access via the store register.
    drive(16'hA001, 3'b000);
    tick();
    tick();
    @(negedge clk);
    e = '0; e.b_sel = 1; e.sext = 16'h0001; e.addr_mem_sel = 1; e.store_ld = 1;
    check_ctl("ldi_exec", e);
    tick();
    @(negedge clk);
    e = '0; e.addr_mem_sel = 2; e.w_rf_sel = 1; e.w_en_rf = 1; e.nzp_sel = 1;
    {e.n_ld, e.z_ld, e.p_ld} = 3'b111;
    check_ctl("ldi_exec2", e);
    tick();
    @(negedge clk);
    check_ctl("ldi_back_to_fetch", k_fetch());

    // STI
    drive(16'hB7FF, 3'b000);
    tick();
    tick();
    @(negedge clk);
    e = '0; e.b_sel = 1; e.sext = 16'hFFFF; e.addr_mem_sel = 1; e.store_ld = 1;
    check_ctl("sti_exec", e);
    tick();
    @(negedge clk);
    e = '0; e.addr_mem_sel = 2; e.r1 = 3'd3; e.w_en_mem = 1;
    check_ctl("sti_exec2", e);
    tick();
    @(negedge clk);
    check_ctl("sti_back_to_fetch", k_fetch());
`ifdef PUNC_INSTR_COUNT_EN
    check_cnt("count_after_vectors", 16'(tv.size() + 2));
`endif

    // Restart, three ADDs, then HALT holds for 20 cycles.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) run_instr(16'h1261);
    drive(16'hF025, 3'b000);
    tick();
    @(negedge clk);
    check_ctl("halt_decode", '0);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(16'($urandom), 3'($urandom));
      @(negedge clk);
      check_ctl("halt_hold", k_halt());
      tick();
    end
`ifdef PUNC_INSTR_COUNT_EN
    check_cnt("count_in_halt", 16'd3);
`endif
    rst = 1'b0;
    @(negedge clk);
    check_ctl("halt_reset_zero", '0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_ctl("init_after_halt", k_init());
    tick();

    // Reset during EXEC of the second ADD: no RF write, back to INIT.
    run_instr(16'h1261);
    drive(16'h1261, 3'b000);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_ctl("reset_mid_exec", '0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_ctl("init_after_mid_reset", k_init());
`ifdef PUNC_INSTR_COUNT_EN
    check_cnt("count_after_mid_reset", 16'd0);
`endif

    // Random instruction stream against the reference model.
    rst = 1'b0;
    tick();
    ph = PH_INIT;
    cnt = 0;
    cur_ir = 16'h0000;
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 39) != 0);
      if (ph == PH_INIT || ph == PH_FETCH || ph == PH_HALT) cur_ir = 16'($urandom);
      fl = 3'($urandom);
      rst = r;
      drive(cur_ir, fl);
      @(negedge clk);
      check_ctl("random", model_ctl(ph, cur_ir, fl, r));
`ifdef PUNC_INSTR_COUNT_EN
      check_cnt("random_count", 16'(cnt));
`endif
      tick();
      if (!r) begin
        ph = PH_INIT;
        cnt = 0;
      end else begin
        nph = next_phase(ph, cur_ir);
        if (nph == PH_FETCH && (ph == PH_EXEC || ph == PH_EXEC2)) cnt = (cnt + 1) % 65536;
        ph = nph;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
